// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants: base opcodes, the canonical NOP and instruction field slicers.
package rv32_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    function automatic logic [6:0] get_opcode(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] get_rs1(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [31:0] instr);
        return instr[24:20];
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with hard-wired x0, out-of-range address masking
// and same-cycle WB write-through so readers never wait for the array update.
module regfile_bypass #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_D,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic            i_we,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data
);

    localparam int         ADDR_W  = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    function automatic logic f_in_range(input logic [4:0] addr);
        return {1'b0, addr} < NREGS_L;
    endfunction

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;
    logic [XLEN-1:0] w_arr_rs1;
    logic [XLEN-1:0] w_arr_rs2;

    assign w_wr_en   = i_we && (i_rd != '0) && f_in_range(i_rd);
    assign w_arr_rs1 = r_regs[i_rs1[ADDR_W-1:0]];
    assign w_arr_rs2 = r_regs[i_rs2[ADDR_W-1:0]];

    // NOTE: the array is reset so every architectural register reads 0 after reset_D;
    // this prevents inference of a plain RAM macro, which is acceptable at this size.
    always_ff @(posedge clk or posedge reset_D) begin
        if (reset_D) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_rd[ADDR_W-1:0]] <= i_wdata;
        end
    end

    assign o_rs1_data = ((i_rs1 == '0) || !f_in_range(i_rs1)) ? '0 :
                        (w_wr_en && (i_rd == i_rs1))          ? i_wdata : w_arr_rs1;
    assign o_rs2_data = ((i_rs2 == '0) || !f_in_range(i_rs2)) ? '0 :
                        (w_wr_en && (i_rd == i_rs2))          ? i_wdata : w_arr_rs2;

endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage: IF/ID pipeline register, register file read with M/WB bypass,
// and load-use hazard detection feeding the fetch/control stall.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          NREGS     = 32,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset_D,
    input  logic            stall_D,
    input  logic            flush_D,
    input  logic            valid_F,
    input  logic [XLEN-1:0] pc_F,
    input  logic [XLEN-1:0] pc_plus4_F,
    input  logic [31:0]     instr_F,
    input  logic            we_M,
    input  logic [4:0]      rd_M,
    input  logic            memread_M,
    input  logic [XLEN-1:0] alu_M,
    input  logic [4:0]      rd_E,
    input  logic            memread_E,
    input  logic            we_WB,
    input  logic [4:0]      rd_WB,
    input  logic [XLEN-1:0] wdata_WB,
    output logic            valid_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] pc_plus4_D,
    output logic [31:0]     instr_D,
    output logic [4:0]      rs1_D,
    output logic [4:0]      rs2_D,
    output logic [4:0]      rd_D,
    output logic [XLEN-1:0] rs1_data_D,
    output logic [XLEN-1:0] rs2_data_D,
    output logic            load_use_stall
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic [31:0]     r_instr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset_D) begin
        if (reset_D) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_instr    <= NOP_INSTR;
        end else if (flush_D) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_instr    <= NOP_INSTR;
        end else if (!(stall_D || load_use_stall)) begin
            r_valid    <= valid_F;
            r_pc       <= pc_F;
            r_pc_plus4 <= pc_plus4_F;
            r_instr    <= instr_F;
        end
    end

    assign valid_D    = r_valid;
    assign pc_D       = r_pc;
    assign pc_plus4_D = r_pc_plus4;
    assign instr_D    = r_instr;
    assign rs1_D      = get_rs1(r_instr);
    assign rs2_D      = get_rs2(r_instr);
    assign rd_D       = get_rd(r_instr);

    logic [XLEN-1:0] w_rf_rs1;
    logic [XLEN-1:0] w_rf_rs2;

    regfile_bypass #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .reset_D    (reset_D),
        .i_rs1      (rs1_D),
        .i_rs2      (rs2_D),
        .i_we       (we_WB),
        .i_rd       (rd_WB),
        .i_wdata    (wdata_WB),
        .o_rs1_data (w_rf_rs1),
        .o_rs2_data (w_rf_rs2)
    );

    // A load's M-stage alu_M is its address, not its data, so loads are never forwarded.
    logic w_fwd_m_rs1;
    logic w_fwd_m_rs2;

    assign w_fwd_m_rs1 = we_M && !memread_M && (rd_M == rs1_D);
    assign w_fwd_m_rs2 = we_M && !memread_M && (rd_M == rs2_D);

    // NOTE: each combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rs1_data_D = w_rf_rs1;
        rs2_data_D = w_rf_rs2;
        if (rs1_D == '0)     rs1_data_D = '0;
        else if (w_fwd_m_rs1) rs1_data_D = alu_M;
        if (rs2_D == '0)     rs2_data_D = '0;
        else if (w_fwd_m_rs2) rs2_data_D = alu_M;
    end

    logic [6:0] w_opcode;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_haz_rs1;
    logic       w_haz_rs2;

    assign w_opcode  = get_opcode(r_instr);
    assign w_use_rs1 = r_valid && !(w_opcode inside {LUI, AUIPC, JAL});
    assign w_use_rs2 = r_valid &&  (w_opcode inside {OP, STORE, BRANCH});

    // A load in E or in M has no data yet; the consumer waits until it reaches WB.
    assign w_haz_rs1 = (rs1_D != '0) &&
                       ((memread_E && (rd_E == rs1_D)) || (memread_M && we_M && (rd_M == rs1_D)));
    assign w_haz_rs2 = (rs2_D != '0) &&
                       ((memread_E && (rd_E == rs2_D)) || (memread_M && we_M && (rd_M == rs2_D)));

    assign load_use_stall = (w_use_rs1 && w_haz_rs1) || (w_use_rs2 && w_haz_rs2);

endmodule
